time_set_uart_rx: RTL
=====================

Name: time_set_uart_rx

Overview:
Serial time-set receiver for the 24-hour clock. It accepts an ASCII command frame on a GPIO UART input (8N1), validates it as a legal HH:MM:SS value, and emits BCD digits with a one-cycle LOAD strobe. The strobe presets the CNT60/CNT24 counter chain. It is the input-direction counterpart to the display path: counters drive HEX outputs, and this block drives the counters from outside.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz.
BAUD, 115200, UART bit rate.
DIV, CLK_HZ/BAUD (434), clocks per bit. Derived localparam, not overridable.

Ports:
CLK  input  1  system clock, all logic on the rising edge.
RESET  input  1  synchronous active-low reset; 0 on the CLK edge resets the block.
RXD  input  1  asynchronous UART line, idle high.
LOAD  output  1  one-cycle pulse; SET_* hold a validated time.
SET_CNT10  output  4  seconds units, BCD 0-9.
SET_CNT6  output  3  seconds tens, 0-5.
SET_CNT10M  output  4  minutes units, 0-9.
SET_CNT6M  output  3  minutes tens, 0-5.
SET_CNT10T  output  4  hours units, 0-9 (0-3 when hours tens = 2).
SET_CNT3T  output  2  hours tens, 0-2.
ERR  output  1  one-cycle pulse on a framing error or an invalid frame.
BUSY  output  1  high while a frame is in progress (after 'T', before CR or abort).

Behaviour:
- Reset (RESET=0 at an edge): all outputs 0, both FSMs idle, synchronizer flops set to 1.
- RXD passes through a 2-flop synchronizer before any use.
- Byte receiver FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a synchronized falling edge starts a bit counter.
  - START: at DIV/2 the line is re-sampled. If high, it was a glitch; return to IDLE with no error.
  - DATA: 8 bits sampled every DIV clocks, LSB first.
  - STOP: sampled at the next DIV. 1 gives a one-cycle byte-valid pulse. 0 is a framing error: the byte is discarded and a frame-abort is raised.
  - The counter reloads at each sample. A new start is accepted immediately after the stop sample.
- Frame format: 'T' (0x54), then six digits H1 H0 M1 M0 S1 S0, then CR (0x0D). No separators.
- Frame parser FSM: WAIT_T, D0..D5, WAIT_CR.
  - WAIT_T: ignores every byte except 'T'. Nothing outside a frame raises ERR.
  - Dn: the byte must be 0x30-0x39 and in range for its position:
    - H1: 0-2.
    - H0: 0-9, or 0-3 if H1=2.
    - M1 and S1: 0-5.
    - M0 and S0: 0-9.
  - A digit is stored in a shadow register as value = byte - 0x30, truncated to the target width.
  - 'T' received in any Dn or WAIT_CR state restarts the frame at D0, with no ERR.
  - Any other invalid byte, including an early CR, gives an ERR pulse and returns to WAIT_T.
  - WAIT_CR: CR copies the shadow registers to SET_* and pulses LOAD. The next cycle returns to WAIT_T. Any other byte gives ERR and returns to WAIT_T.
- Latency: LOAD and ERR assert on the cycle after the byte-valid (or frame-abort) pulse. SET_* update on the same edge LOAD asserts. Frame-abort means ERR plus a return to WAIT_T.
- LOAD and ERR are mutually exclusive. SET_* never change except on a LOAD edge, so the last valid time holds indefinitely.
- BUSY is 1 in D0..WAIT_CR and 0 in WAIT_T. It falls on the same edge LOAD or ERR rises.
- The block does not arbitrate with a KEY-based TSET or with the 1 Hz ENABLE. The consumer gives LOAD priority over a same-cycle increment.
- Reset asserted mid-byte or mid-frame: both FSMs go idle, the shadow registers are cleared, and no LOAD or ERR is emitted.

Decomposition:
- Shared package/header holds:
  - ASCII_T = 8'h54, ASCII_CR = 8'h0D, ASCII_0 = 8'h30.
  - Parser state encodings.
  - The byte receiver state encodings.
- One sub-module, uart_rx_byte:
  - Inputs: CLK, RESET, RXD.
  - Outputs: DATA[7:0], VALID, FERR.
  - Parameter: DIV.
  - Contains the synchronizer and the byte receiver FSM.
- time_set_uart_rx instantiates uart_rx_byte and contains the parser, range checks and output registers.

Test Plan:
- Send "T235958\r" at 115200 -> one LOAD pulse; CNT3T=2, CNT10T=3, CNT6M=5, CNT10M=9, CNT6=5, CNT10=8; ERR never high.
- Send "T240000\r" -> ERR pulse on the '4' byte, no LOAD, SET_* keep their prior values; a following "T000000\r" -> LOAD, all SET_*=0.
- Send "T12T0930\r"... then "T093000\r" -> the second 'T' restarts with no ERR; LOAD with 09:30:00.
- Corrupt the stop bit of M0 (hold RXD low through the stop bit) -> one ERR pulse, BUSY falls; the next valid frame loads normally.
- A 0.3-bit low glitch on idle RXD -> no byte, no ERR; "x5\r" outside a frame -> nothing asserted.
- Assert RESET=0 for one cycle after "T1234" -> all outputs 0; then "56\r" -> no LOAD, no ERR.

Source files
------------

// File: rtl/time_set_uart_rx_pkg.sv
// Shared constants, state encodings and time payload for the UART time-set receiver.
package time_set_uart_rx_pkg;

    localparam logic [7:0] ASCII_T  = 8'h54;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_9  = 8'h39;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        P_WAIT_T,
        P_D0,
        P_D1,
        P_D2,
        P_D3,
        P_D4,
        P_D5,
        P_WAIT_CR
    } parse_state_t;

    // HH:MM:SS as BCD digits, most significant first
    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [2:0] m1;
        logic [3:0] m0;
        logic [2:0] s1;
        logic [3:0] s0;
    } time_bcd_t;

    // Largest legal digit for the frame position; hours units depend on hours tens
    function automatic logic [3:0] digit_max(input parse_state_t s, input logic [1:0] h1);
        logic [3:0] m;
        m = 4'd9;
        case (s)
            P_D0:       m = 4'd2;
            P_D1:       m = (h1 == 2'd2) ? 4'd3 : 4'd9;
            P_D2, P_D4: m = 4'd5;
            default:    m = 4'd9;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/time_set_uart_rx_uart_rx_byte.sv
// 8N1 UART byte receiver with input synchronizer; pulses VALID on a good stop bit, FERR on a bad one.
module uart_rx_byte
    import time_set_uart_rx_pkg::*;
#(
    parameter int unsigned DIV = 434
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RXD,
    output logic [7:0] DATA,
    output logic       VALID,
    output logic       FERR
);

    localparam int unsigned HALF = DIV / 2;
    localparam int unsigned CW   = (DIV > 1) ? $clog2(DIV) : 1;

    logic            r_sync1;
    logic            r_sync2;
    logic            r_prev;
    rx_state_t       r_state;
    rx_state_t       w_next;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_valid;
    logic            r_ferr;
    logic            w_fall;
    logic            w_half;
    logic            w_full;
    logic            w_valid_c;
    logic            w_ferr_c;

    assign w_fall = r_prev & ~r_sync2;
    assign w_half = (r_cnt == CW'(HALF - 1));
    assign w_full = (r_cnt == CW'(DIV - 1));

    assign DATA  = r_shift;
    assign VALID = r_valid;
    assign FERR  = r_ferr;

    // Two-flop synchronizer plus one delayed copy for edge detection
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= RXD;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            RX_IDLE:  if (w_fall) w_next = RX_START;
            RX_START: if (w_half) w_next = r_sync2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_full && (r_bit == 3'd7)) w_next = RX_STOP;
            RX_STOP:  if (w_full) w_next = RX_IDLE;
            default:  w_next = RX_IDLE;
        endcase
    end

    always_comb begin
        w_valid_c = 1'b0;
        w_ferr_c  = 1'b0;
        if ((r_state == RX_STOP) && w_full) begin
            w_valid_c = r_sync2;
            w_ferr_c  = ~r_sync2;
        end
    end

    // Bit timing, shift register and registered strobes
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_valid <= w_valid_c;
            r_ferr  <= w_ferr_c;
            case (r_state)
                RX_START: r_cnt <= w_half ? '0 : r_cnt + CW'(1);
                RX_DATA: begin
                    if (w_full) begin
                        r_cnt   <= '0;
                        r_bit   <= r_bit + 3'd1;
                        r_shift <= {r_sync2, r_shift[7:1]};
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                RX_STOP: r_cnt <= w_full ? '0 : r_cnt + CW'(1);
                default: begin
                    r_cnt <= '0;
                    r_bit <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/time_set_uart_rx.sv
// Serial "THHMMSS<CR>" time-set receiver: validates the frame and presets the counter chain via LOAD.
module time_set_uart_rx
    import time_set_uart_rx_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 115_200
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RXD,
    output logic       LOAD,
    output logic [3:0] SET_CNT10,
    output logic [2:0] SET_CNT6,
    output logic [3:0] SET_CNT10M,
    output logic [2:0] SET_CNT6M,
    output logic [3:0] SET_CNT10T,
    output logic [1:0] SET_CNT3T,
    output logic       ERR,
    output logic       BUSY
);

    localparam int unsigned DIV = CLK_HZ / BAUD;

    logic [7:0]   w_byte;
    logic         w_valid;
    logic         w_ferr;
    logic [3:0]   w_digit;
    logic         w_is_digit;
    logic         w_digit_ok;
    logic         w_in_frame;
    logic         w_load_c;
    logic         w_err_c;
    logic         w_store_c;
    parse_state_t r_state;
    parse_state_t w_next;
    time_bcd_t    r_shadow;
    time_bcd_t    r_set;
    logic         r_load;
    logic         r_err;
    logic         r_busy;

    uart_rx_byte #(
        .DIV (DIV)
    ) u_rx (
        .CLK   (CLK),
        .RESET (RESET),
        .RXD   (RXD),
        .DATA  (w_byte),
        .VALID (w_valid),
        .FERR  (w_ferr)
    );

    assign w_is_digit = (w_byte >= ASCII_0) && (w_byte <= ASCII_9);
    assign w_digit    = 4'(w_byte - ASCII_0);
    assign w_digit_ok = w_is_digit && (w_digit <= digit_max(r_state, r_shadow.h1));
    assign w_in_frame = (r_state != P_WAIT_T);

    assign LOAD       = r_load;
    assign ERR        = r_err;
    assign BUSY       = r_busy;
    assign SET_CNT3T  = r_set.h1;
    assign SET_CNT10T = r_set.h0;
    assign SET_CNT6M  = r_set.m1;
    assign SET_CNT10M = r_set.m0;
    assign SET_CNT6   = r_set.s1;
    assign SET_CNT10  = r_set.s0;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state <= P_WAIT_T;
        end else begin
            r_state <= w_next;
        end
    end

    // A 'T' anywhere restarts the frame; aborts and bad bytes fall back to WAIT_T
    always_comb begin
        w_next = r_state;
        if (!w_in_frame) begin
            if (w_valid && (w_byte == ASCII_T)) w_next = P_D0;
        end else if (w_ferr) begin
            w_next = P_WAIT_T;
        end else if (w_valid) begin
            if (w_byte == ASCII_T) begin
                w_next = P_D0;
            end else if ((r_state == P_WAIT_CR) || !w_digit_ok) begin
                w_next = P_WAIT_T;
            end else begin
                case (r_state)
                    P_D0:    w_next = P_D1;
                    P_D1:    w_next = P_D2;
                    P_D2:    w_next = P_D3;
                    P_D3:    w_next = P_D4;
                    P_D4:    w_next = P_D5;
                    P_D5:    w_next = P_WAIT_CR;
                    default: w_next = P_WAIT_T;
                endcase
            end
        end
    end

    always_comb begin
        w_load_c  = 1'b0;
        w_err_c   = 1'b0;
        w_store_c = 1'b0;
        if (w_in_frame) begin
            if (w_ferr) begin
                w_err_c = 1'b1;
            end else if (w_valid && (w_byte != ASCII_T)) begin
                if (r_state == P_WAIT_CR) begin
                    w_load_c = (w_byte == ASCII_CR);
                    w_err_c  = (w_byte != ASCII_CR);
                end else begin
                    w_store_c = w_digit_ok;
                    w_err_c   = ~w_digit_ok;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_load   <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
            r_shadow <= '0;
            r_set    <= '0;
        end else begin
            r_load <= w_load_c;
            r_err  <= w_err_c;
            r_busy <= (w_next != P_WAIT_T);
            if (w_store_c) begin
                case (r_state)
                    P_D0:    r_shadow.h1 <= 2'(w_digit);
                    P_D1:    r_shadow.h0 <= w_digit;
                    P_D2:    r_shadow.m1 <= 3'(w_digit);
                    P_D3:    r_shadow.m0 <= w_digit;
                    P_D4:    r_shadow.s1 <= 3'(w_digit);
                    P_D5:    r_shadow.s0 <= w_digit;
                    default: ;
                endcase
            end
            if (w_load_c) r_set <= r_shadow;
        end
    end

endmodule
